// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID latch, 32-entry register file, field decode and
// load-use hazard detection feeding registered ID/EX outputs. Optional macro: WB_BYPASS_EN.
module id_stage #(
   parameter int REG_ADDR_W = 5,
   parameter int DATA_W     = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_W-1:0]     IF_Ins,
   input  logic [DATA_W-1:0]     IF_nextPC,
   input  logic                  IF_Valid,
   input  logic                  Flush,
   input  logic                  WB_WE,
   input  logic [REG_ADDR_W-1:0] WB_Addr,
   input  logic [DATA_W-1:0]     WB_Data,
   input  logic                  EX_MemRead,
   input  logic [REG_ADDR_W-1:0] EX_Rt,
   output logic                  Stall,
   output logic                  ID_Valid,
   output logic [DATA_W-1:0]     ID_nextPC,
   output logic [5:0]            ID_Op,
   output logic [5:0]            ID_Funct,
   output logic [REG_ADDR_W-1:0] ID_Rs,
   output logic [REG_ADDR_W-1:0] ID_Rt,
   output logic [REG_ADDR_W-1:0] ID_Rd,
   output logic [4:0]            ID_Shamt,
   output logic [DATA_W-1:0]     ID_Imm32,
   output logic [DATA_W-1:0]     ID_JTarget,
   output logic [DATA_W-1:0]     ID_RsData,
   output logic [DATA_W-1:0]     ID_RtData
);

   localparam int NREGS = 2 ** REG_ADDR_W;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_SW    = 6'h2B;

   function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
      return {{(DATA_W-16){v[15]}}, v};
   endfunction

   function automatic logic [DATA_W-1:0] jtarget(input logic [DATA_W-1:0] pc,
                                                 input logic [25:0]       idx);
      return {pc[DATA_W-1:DATA_W-4], idx, 2'b00};
   endfunction

   // IF/ID latch
   logic [DATA_W-1:0] ifid_ins_q, ifid_ins_d;
   logic [DATA_W-1:0] ifid_pc_q,  ifid_pc_d;
   logic              ifid_vld_q, ifid_vld_d;

   logic [DATA_W-1:0] rf_q [NREGS];

   logic [5:0]            dec_op;
   logic [5:0]            dec_funct;
   logic [REG_ADDR_W-1:0] dec_rs;
   logic [REG_ADDR_W-1:0] dec_rt;
   logic [REG_ADDR_W-1:0] dec_rd;
   logic [4:0]            dec_shamt;
   logic                  rs_used;
   logic                  rt_used;
   logic                  load_use;
   logic                  bubble;
   logic [DATA_W-1:0]     rs_data;
   logic [DATA_W-1:0]     rt_data;

   always_comb begin
      dec_op    = ifid_ins_q[31:26];
      dec_rs    = ifid_ins_q[21 +: REG_ADDR_W];
      dec_rt    = ifid_ins_q[16 +: REG_ADDR_W];
      dec_rd    = ifid_ins_q[11 +: REG_ADDR_W];
      dec_shamt = ifid_ins_q[10:6];
      dec_funct = ifid_ins_q[5:0];
   end

   always_comb begin
      rs_used = !((dec_op == OP_J) || (dec_op == OP_JAL));
      rt_used = (dec_op == OP_RTYPE) || (dec_op == OP_BEQ) ||
                (dec_op == OP_BNE)   || (dec_op == OP_SW);
   end

   // A taken branch in EX makes the stall moot, so Flush wins.
   always_comb begin
      load_use = ifid_vld_q && EX_MemRead && (EX_Rt != '0) &&
                 (((EX_Rt == dec_rs) && rs_used) || ((EX_Rt == dec_rt) && rt_used));
      Stall    = RST && !Flush && load_use;
      bubble   = Flush || Stall || !ifid_vld_q;
   end

   always_comb begin
      ifid_ins_d = ifid_ins_q;
      ifid_pc_d  = ifid_pc_q;
      ifid_vld_d = ifid_vld_q;
      if (Flush) begin
         ifid_ins_d = '0;
         ifid_pc_d  = '0;
         ifid_vld_d = 1'b0;
      end else if (!Stall) begin
         ifid_ins_d = IF_Ins;
         ifid_pc_d  = IF_nextPC;
         ifid_vld_d = IF_Valid;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ifid_ins_q <= '0;
         ifid_pc_q  <= '0;
         ifid_vld_q <= 1'b0;
      end else begin
         ifid_ins_q <= ifid_ins_d;
         ifid_pc_q  <= ifid_pc_d;
         ifid_vld_q <= ifid_vld_d;
      end
   end

   // Register file; entry 0 is never written so it stays zero after reset.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
      end else if (WB_WE && (WB_Addr != '0)) begin
         rf_q[WB_Addr] <= WB_Data;
      end
   end

   always_comb begin
      rs_data = (dec_rs == '0) ? '0 : rf_q[dec_rs];
      rt_data = (dec_rt == '0) ? '0 : rf_q[dec_rt];
`ifdef WB_BYPASS_EN
      if (WB_WE && (WB_Addr != '0) && (WB_Addr == dec_rs)) begin
         rs_data = WB_Data;
      end
      if (WB_WE && (WB_Addr != '0) && (WB_Addr == dec_rt)) begin
         rt_data = WB_Data;
      end
`endif
   end

   // ID/EX register
   logic                  idex_vld_q,   idex_vld_d;
   logic [DATA_W-1:0]     idex_pc_q,    idex_pc_d;
   logic [5:0]            idex_op_q,    idex_op_d;
   logic [5:0]            idex_funct_q, idex_funct_d;
   logic [REG_ADDR_W-1:0] idex_rs_q,    idex_rs_d;
   logic [REG_ADDR_W-1:0] idex_rt_q,    idex_rt_d;
   logic [REG_ADDR_W-1:0] idex_rd_q,    idex_rd_d;
   logic [4:0]            idex_shamt_q, idex_shamt_d;
   logic [DATA_W-1:0]     idex_imm_q,   idex_imm_d;
   logic [DATA_W-1:0]     idex_jt_q,    idex_jt_d;
   logic [DATA_W-1:0]     idex_rsd_q,   idex_rsd_d;
   logic [DATA_W-1:0]     idex_rtd_q,   idex_rtd_d;

   always_comb begin
      idex_vld_d   = 1'b0;
      idex_pc_d    = '0;
      idex_op_d    = '0;
      idex_funct_d = '0;
      idex_rs_d    = '0;
      idex_rt_d    = '0;
      idex_rd_d    = '0;
      idex_shamt_d = '0;
      idex_imm_d   = '0;
      idex_jt_d    = '0;
      idex_rsd_d   = '0;
      idex_rtd_d   = '0;
      if (!bubble) begin
         idex_vld_d   = 1'b1;
         idex_pc_d    = ifid_pc_q;
         idex_op_d    = dec_op;
         idex_funct_d = dec_funct;
         idex_rs_d    = dec_rs;
         idex_rt_d    = dec_rt;
         idex_rd_d    = dec_rd;
         idex_shamt_d = dec_shamt;
         idex_imm_d   = sext16(ifid_ins_q[15:0]);
         idex_jt_d    = jtarget(ifid_pc_q, ifid_ins_q[25:0]);
         idex_rsd_d   = rs_data;
         idex_rtd_d   = rt_data;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         idex_vld_q   <= 1'b0;
         idex_pc_q    <= '0;
         idex_op_q    <= '0;
         idex_funct_q <= '0;
         idex_rs_q    <= '0;
         idex_rt_q    <= '0;
         idex_rd_q    <= '0;
         idex_shamt_q <= '0;
         idex_imm_q   <= '0;
         idex_jt_q    <= '0;
         idex_rsd_q   <= '0;
         idex_rtd_q   <= '0;
      end else begin
         idex_vld_q   <= idex_vld_d;
         idex_pc_q    <= idex_pc_d;
         idex_op_q    <= idex_op_d;
         idex_funct_q <= idex_funct_d;
         idex_rs_q    <= idex_rs_d;
         idex_rt_q    <= idex_rt_d;
         idex_rd_q    <= idex_rd_d;
         idex_shamt_q <= idex_shamt_d;
         idex_imm_q   <= idex_imm_d;
         idex_jt_q    <= idex_jt_d;
         idex_rsd_q   <= idex_rsd_d;
         idex_rtd_q   <= idex_rtd_d;
      end
   end

   assign ID_Valid   = idex_vld_q;
   assign ID_nextPC  = idex_pc_q;
   assign ID_Op      = idex_op_q;
   assign ID_Funct   = idex_funct_q;
   assign ID_Rs      = idex_rs_q;
   assign ID_Rt      = idex_rt_q;
   assign ID_Rd      = idex_rd_q;
   assign ID_Shamt   = idex_shamt_q;
   assign ID_Imm32   = idex_imm_q;
   assign ID_JTarget = idex_jt_q;
   assign ID_RsData  = idex_rsd_q;
   assign ID_RtData  = idex_rtd_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed stimulus pushes hand-computed ID/EX and Stall
// expectations tagged with the cycle they are due; a negedge monitor pops and compares.
module tb_id_stage;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] IF_Ins, IF_nextPC, WB_Data;
   logic        IF_Valid, Flush, WB_WE, EX_MemRead;
   logic [4:0]  WB_Addr, EX_Rt;
   logic        Stall, ID_Valid;
   logic [31:0] ID_nextPC, ID_Imm32, ID_JTarget, ID_RsData, ID_RtData;
   logic [5:0]  ID_Op, ID_Funct;
   logic [4:0]  ID_Rs, ID_Rt, ID_Rd, ID_Shamt;

   id_stage dut (
      .CLK(CLK), .RST(RST),
      .IF_Ins(IF_Ins), .IF_nextPC(IF_nextPC), .IF_Valid(IF_Valid), .Flush(Flush),
      .WB_WE(WB_WE), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
      .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .Stall(Stall),
      .ID_Valid(ID_Valid), .ID_nextPC(ID_nextPC), .ID_Op(ID_Op), .ID_Funct(ID_Funct),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_Shamt(ID_Shamt),
      .ID_Imm32(ID_Imm32), .ID_JTarget(ID_JTarget),
      .ID_RsData(ID_RsData), .ID_RtData(ID_RtData)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int          tag;
      logic        v;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd, sh;
      logic [31:0] imm, jt, pc, rsd, rtd;
   } exp_t;
   typedef struct {
      int   tag;
      logic st;
   } st_t;

   exp_t exq[$];
   st_t  stq[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic push_id(input int tag, input logic v, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [4:0] sh, input logic [31:0] imm, input logic [31:0] jt,
                          input logic [31:0] pc, input logic [31:0] rsd, input logic [31:0] rtd);
      exp_t e;
      e.tag = tag; e.v = v; e.op = op; e.fn = fn; e.rs = rs; e.rt = rt; e.rd = rd; e.sh = sh;
      e.imm = imm; e.jt = jt; e.pc = pc; e.rsd = rsd; e.rtd = rtd;
      exq.push_back(e);
   endtask

   task automatic push_bub(input int tag);
      push_id(tag, 1'b0, 6'h0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic push_st(input int tag, input logic st);
      st_t s;
      s.tag = tag; s.st = st;
      stq.push_back(s);
   endtask

   // Monitor
   always @(negedge CLK) begin
      while (exq.size() > 0 && exq[0].tag <= cyc) begin
         exp_t e;
         e = exq.pop_front();
         if (e.tag < cyc) begin
            chk("id_missed_slot", 32'(cyc), 32'(e.tag));
         end else begin
            chk("ID_Valid",   32'(ID_Valid),  32'(e.v));
            chk("ID_Op",      32'(ID_Op),     32'(e.op));
            chk("ID_Funct",   32'(ID_Funct),  32'(e.fn));
            chk("ID_Rs",      32'(ID_Rs),     32'(e.rs));
            chk("ID_Rt",      32'(ID_Rt),     32'(e.rt));
            chk("ID_Rd",      32'(ID_Rd),     32'(e.rd));
            chk("ID_Shamt",   32'(ID_Shamt),  32'(e.sh));
            chk("ID_Imm32",   ID_Imm32,   e.imm);
            chk("ID_JTarget", ID_JTarget, e.jt);
            chk("ID_nextPC",  ID_nextPC,  e.pc);
            chk("ID_RsData",  ID_RsData,  e.rsd);
            chk("ID_RtData",  ID_RtData,  e.rtd);
         end
      end
      while (stq.size() > 0 && stq[0].tag <= cyc) begin
         st_t s;
         s = stq.pop_front();
         if (s.tag < cyc) chk("stall_missed_slot", 32'(cyc), 32'(s.tag));
         else             chk("Stall", 32'(Stall), 32'(s.st));
      end
   end

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic mr, input logic [4:0] ert, input logic fl);
      IF_Ins = ins; IF_nextPC = pc; IF_Valid = v;
      WB_WE = we; WB_Addr = wa; WB_Data = wd;
      EX_MemRead = mr; EX_Rt = ert; Flush = fl;
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   logic [31:0] exp_bypass;

   initial begin
`ifdef WB_BYPASS_EN
      exp_bypass = 32'hCAFEF00D;
`else
      exp_bypass = 32'h12345678;
`endif
      drive(32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0);
      RST = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_ID_Valid", 32'(ID_Valid), 32'h0);
      chk("reset_Stall", 32'(Stall), 32'h0);
      chk("reset_ID_RsData", ID_RsData, 32'h0);
      RST = 1'b1;

      // Write $8, IF idle
      drive(32'h0, 32'h0, 0, 1, 5'd8, 32'h12345678, 0, 5'd0, 0);
      push_bub(cyc + 2); tick;
      // add $10,$8,$8 ; attempt write to $0
      drive(32'h01085020, 32'h4, 1, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 0);
      push_id(cyc + 2, 1, 6'h00, 6'h20, 5'd8, 5'd8, 5'd10, 5'd0, 32'h00005020, 32'h04214080,
              32'h4, 32'h12345678, 32'h12345678);
      tick;
      // add $1,$0,$8 ; write $5
      drive(32'h00080820, 32'h8, 1, 1, 5'd5, 32'hA5A5A5A5, 0, 5'd0, 0);
      push_id(cyc + 2, 1, 6'h00, 6'h20, 5'd0, 5'd8, 5'd1, 5'd0, 32'h00000820, 32'h00202080,
              32'h8, 32'h0, 32'h12345678);
      tick;
      // addi $9,$8,-4
      drive(32'h2109FFFC, 32'h10, 1, 0, 5'd0, 32'h0, 0, 5'd0, 0);
      push_id(cyc + 2, 1, 6'h08, 6'h3C, 5'd8, 5'd9, 5'd31, 5'd31, 32'hFFFFFFFC, 32'h0427FFF0,
              32'h10, 32'h12345678, 32'h0);
      tick;
      // j with upper PC bits
      drive(32'h08000004, 32'h40000010, 1, 0, 5'd0, 32'h0, 0, 5'd0, 0);
      push_id(cyc + 2, 1, 6'h02, 6'h04, 5'd0, 5'd0, 5'd0, 5'd0, 32'h4, 32'h40000010,
              32'h40000010, 32'h0, 32'h0);
      tick;
      // add $10,$9,$8 enters IF/ID next
      drive(32'h01285020, 32'h14, 1, 0, 5'd0, 32'h0, 0, 5'd0, 0);
      push_st(cyc, 0);
      tick;
      // load to $9 in EX: stall, bubble out, IF holds
      drive(32'h00086022, 32'h18, 1, 0, 5'd0, 32'h0, 1, 5'd9, 0);
      push_st(cyc, 1);
      push_bub(cyc + 1);
      tick;
      // load gone: held add issues, IF re-presents the sub
      drive(32'h00086022, 32'h18, 1, 0, 5'd0, 32'h0, 0, 5'd0, 0);
      push_st(cyc, 0);
      push_id(cyc + 1, 1, 6'h00, 6'h20, 5'd9, 5'd8, 5'd10, 5'd0, 32'h00005020, 32'h04A14080,
              32'h14, 32'h0, 32'h12345678);
      push_id(cyc + 2, 1, 6'h00, 6'h22, 5'd0, 5'd8, 5'd12, 5'd0, 32'h00006022, 32'h00218088,
              32'h18, 32'h0, 32'h12345678);
      tick;
      // load to $0 while IF/ID reads $0: no stall ; present beq $8,$9
      drive(32'h11090003, 32'h1C, 1, 0, 5'd0, 32'h0, 1, 5'd0, 0);
      push_st(cyc, 0);
      tick;
      // beq uses $9 as Rt with load to $9, but Flush wins
      drive(32'h01086022, 32'h20, 1, 0, 5'd0, 32'h0, 1, 5'd9, 1);
      push_st(cyc, 0);
      push_bub(cyc + 1);
      push_bub(cyc + 2);
      tick;
      // add $13,$8,$0
      drive(32'h01006820, 32'h24, 1, 0, 5'd0, 32'h0, 0, 5'd0, 0);
      push_id(cyc + 2, 1, 6'h00, 6'h20, 5'd8, 5'd0, 5'd13, 5'd0, 32'h00006820, 32'h0401A080,
              32'h24, exp_bypass, 32'h0);
      tick;
      // WB $8 while add $13 is read ; present add $14,$8,$5
      drive(32'h01057020, 32'h28, 1, 1, 5'd8, 32'hCAFEF00D, 0, 5'd0, 0);
      push_id(cyc + 2, 1, 6'h00, 6'h20, 5'd8, 5'd5, 5'd14, 5'd0, 32'h00007020, 32'h0415C080,
              32'h28, 32'hCAFEF00D, 32'hA5A5A5A5);
      tick;
      drive(32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0);
      push_bub(cyc + 2);
      tick;

      // Asynchronous reset while ID_Valid is high
      @(negedge CLK);
      #1;
      chk("pre_reset_ID_Valid", 32'(ID_Valid), 32'h1);
      RST = 1'b0;
      #1;
      chk("async_ID_Valid", 32'(ID_Valid), 32'h0);
      chk("async_ID_RsData", ID_RsData, 32'h0);
      chk("async_ID_RtData", ID_RtData, 32'h0);
      chk("async_ID_nextPC", ID_nextPC, 32'h0);
      chk("async_ID_Rd", 32'(ID_Rd), 32'h0);
      chk("async_ID_Imm32", ID_Imm32, 32'h0);
      chk("async_ID_JTarget", ID_JTarget, 32'h0);
      chk("async_Stall", 32'(Stall), 32'h0);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      // add $1,$5,$5: $5 cleared by reset
      drive(32'h00A50820, 32'h30, 1, 0, 5'd0, 32'h0, 0, 5'd0, 0);
      push_id(cyc + 2, 1, 6'h00, 6'h20, 5'd5, 5'd5, 5'd1, 5'd0, 32'h00000820, 32'h02942080,
              32'h30, 32'h0, 32'h0);
      tick;
      drive(32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0);
      push_bub(cyc + 2);
      tick;

      for (int i = 0; i < 10; i++) begin
         if (exq.size() == 0 && stq.size() == 0) break;
         tick;
      end
      if (exq.size() != 0 || stq.size() != 0) begin
         chk("scoreboard_drain", 32'(exq.size() + stq.size()), 32'h0);
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
